// File: rtl/av_mm_pkg.sv
// -----------------------------------------------------------------------------
// av_mm_pkg
// Shared types for the Avalon-MM single-transaction master.
//   - av_dw_def / av_aw_def : default data / word-address widths
//   - state_e               : master FSM states (also exported as a debug port)
//   - cmd_t                 : command record {write, addr, byteen, wdata} at the
//                             default widths; the master keeps the same fields
//                             at its own parameter widths.
// -----------------------------------------------------------------------------
package av_mm_pkg;

  localparam int AV_DW_DEF = 32;
  localparam int AV_AW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    RSP     = 2'd3
  } state_e;

  typedef struct packed {
    logic                   write;
    logic [AV_AW_DEF-1:0]   addr;
    logic [AV_DW_DEF/8-1:0] byteen;
    logic [AV_DW_DEF-1:0]   wdata;
  } cmd_t;

endpackage

// File: rtl/av_mm_master.sv
// -----------------------------------------------------------------------------
// av_mm_master
// Turns one command at a time into a single Avalon-MM read or write and
// returns a one-cycle response. Exactly one transaction is ever outstanding.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_byteen_i, cmd_wdata_i command payload
//   rsp_valid_o, rsp_write_o,
//   rsp_err_o, rsp_rdata_o    one-cycle response (no backpressure)
//   avm_*                     Avalon-MM master request / return
//   dbg_state_o               current FSM state
//
// Build option
//   AV_MM_MASTER_TIMEOUT_EN : when defined, a watchdog counts busy cycles in
//   REQ/WAIT_RD and, after TIMEOUT_CYC of them, forces an error response.
//   When undefined there is no counter, rsp_err_o is 0 and the master waits
//   for the slave indefinitely.
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both 1; cmd_ready_o is 1 only in IDLE and does not depend
// on cmd_valid_i. The response is a single rsp_valid_o pulse the consumer
// must take when it appears.
// -----------------------------------------------------------------------------
module av_mm_master
  import av_mm_pkg::*;
#(
  parameter int DW          = AV_DW_DEF,
  parameter int AW          = AV_AW_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_write_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [DW/8-1:0] cmd_byteen_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  output logic            rsp_valid_o,
  output logic            rsp_write_o,
  output logic            rsp_err_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic [AW-1:0]   avm_address,
  output logic [DW/8-1:0] avm_byteenable,
  output logic            avm_read,
  output logic            avm_write,
  output logic [DW-1:0]   avm_writedata,
  input  logic            avm_waitrequest,
  input  logic [DW-1:0]   avm_readdata,
  input  logic            avm_readdatavalid,
  output state_e          dbg_state_o
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW/8-1:0]   byteen_q, byteen_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;

`ifdef AV_MM_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      byteen_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef AV_MM_MASTER_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      byteen_q <= byteen_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef AV_MM_MASTER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    byteen_d = byteen_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef AV_MM_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          write_d  = cmd_write_i;
          addr_d   = cmd_addr_i;
          byteen_d = cmd_byteen_i;
          wdata_d  = cmd_wdata_i;
          state_d  = REQ;
`ifdef AV_MM_MASTER_TIMEOUT_EN
          cnt_d    = '0;
          err_d    = 1'b0;
`endif
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          if (write_q) begin
            rdata_d = '0;
            state_d = RSP;
          end else if (avm_readdatavalid) begin
            // Zero-latency slave: data returns in the acceptance cycle.
            rdata_d = avm_readdata;
            state_d = RSP;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          state_d = RSP;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef AV_MM_MASTER_TIMEOUT_EN
    // A genuine completion in the last allowed cycle beats the watchdog.
    if (state_q == REQ || state_q == WAIT_RD) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_d != RSP && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d = RSP;
        err_d   = 1'b1;
        rdata_d = '0;
      end
    end
`endif
  end

  // Bus strobes decode straight from the state register so an asynchronous
  // reset removes them without waiting for a clock edge.
  assign cmd_ready_o    = (state_q == IDLE);
  assign avm_read       = (state_q == REQ) && !write_q;
  assign avm_write      = (state_q == REQ) &&  write_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = byteen_q;
  assign avm_writedata  = wdata_q;
  assign rsp_valid_o    = (state_q == RSP);
  assign rsp_write_o    = (state_q == RSP) && write_q;
  assign rsp_rdata_o    = rdata_q;
  assign dbg_state_o    = state_q;

`ifdef AV_MM_MASTER_TIMEOUT_EN
  assign rsp_err_o = (state_q == RSP) && err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_av_mm_master.sv
// -----------------------------------------------------------------------------
// tb_av_mm_master
// Self-checking bench for av_mm_master. A table of directed transactions and a
// batch of random ones are issued against a bench-side Avalon slave; expected
// latency, strobe count and read data come from a cycle-count model of the
// protocol, with expected response data kept in exp_q. Hand-written
// sequences cover back-to-back commands, reset mid-transaction and a stuck
// waitrequest (watchdog behaviour when AV_MM_MASTER_TIMEOUT_EN is defined).
// -----------------------------------------------------------------------------
module tb_av_mm_master;
  import av_mm_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW/8-1:0] cmd_byteen;
  logic [DW-1:0]   cmd_wdata;
  logic            rsp_valid, rsp_write, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   avm_address;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_read, avm_write;
  logic [DW-1:0]   avm_writedata;
  logic            avm_waitrequest, avm_readdatavalid;
  logic [DW-1:0]   avm_readdata;
  state_e          dbg_state;

  av_mm_master #(.DW(DW), .AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (cmd_ready),
    .cmd_write_i       (cmd_write),
    .cmd_addr_i        (cmd_addr),
    .cmd_byteen_i      (cmd_byteen),
    .cmd_wdata_i       (cmd_wdata),
    .rsp_valid_o       (rsp_valid),
    .rsp_write_o       (rsp_write),
    .rsp_err_o         (rsp_err),
    .rsp_rdata_o       (rsp_rdata),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .dbg_state_o       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // w = waitrequest-high cycles before acceptance
  // l = cycles from acceptance to readdatavalid (0 = same cycle)
  typedef struct {
    logic            wr;
    logic [AW-1:0]   addr;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   wd;
    int              w;
    int              l;
    logic [DW-1:0]   rd;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    cmd_valid         = 1'b0;
    cmd_write         = 1'b0;
    cmd_addr          = '0;
    cmd_byteen        = '0;
    cmd_wdata         = '0;
    avm_waitrequest   = 1'b1;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW/8-1:0] be,
                       input logic [DW-1:0] wd);
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_addr   = a;
    cmd_byteen = be;
    cmd_wdata  = wd;
  endtask

  // Issues one command at a negedge in IDLE and plays the slave until the
  // response. Cycle k counts negedges after the accepting edge.
  task automatic run_txn(input vec_t v);
    int   k, req_cnt, since, exp_lat;
    logic dropped, got;
    logic [DW-1:0] exp_rd, held;
    exp_rd  = v.wr ? '0 : v.rd;
    exp_lat = v.wr ? v.w + 2 : v.w + 2 + v.l;
    exp_q.push_back(exp_rd);

    check("ready_before_cmd", cmd_ready, 1);
    issue(v.wr, v.addr, v.be, v.wd);
    avm_waitrequest = 1'b1;
    @(negedge clk);
    // Scramble the payload: the bus must keep showing the registered copy.
    cmd_valid  = 1'b0;
    cmd_addr   = AW'($urandom);
    cmd_byteen = (DW/8)'($urandom);
    cmd_wdata  = $urandom;
    k = 1; req_cnt = 0; since = 0; dropped = 1'b0; got = 1'b0;
    while (!got && k < 200) begin
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b1;
      if (rsp_valid) begin
        got = 1'b1;
        check("rsp_latency", k, exp_lat);
        check("strobe_cycles", req_cnt, v.w + 1);
        check("rsp_write", rsp_write, v.wr);
        check("rsp_err", rsp_err, 0);
        check("rsp_rdata", rsp_rdata, exp_q.pop_front());
        check("strobes_in_rsp", {avm_read, avm_write}, 0);
        // Stray readdatavalid during RSP must be ignored.
        avm_readdatavalid = 1'b1;
        avm_readdata      = ~exp_rd;
        held              = exp_rd;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        check("rsp_one_cycle", rsp_valid, 0);
        check("ready_after_rsp", cmd_ready, 1);
        check("rdata_held", rsp_rdata, held);
      end else begin
        if (avm_read || avm_write) begin
          req_cnt++;
          check("strobe_type", {avm_read, avm_write}, v.wr ? 2'b01 : 2'b10);
          check("avm_address", avm_address, v.addr);
          check("avm_byteenable", avm_byteenable, v.be);
          if (v.wr) check("avm_writedata", avm_writedata, v.wd);
          if (req_cnt > v.w) begin
            avm_waitrequest = 1'b0;
            dropped         = 1'b1;
            if (!v.wr && v.l == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata      = v.rd;
            end
          end
        end else if (dropped) begin
          since++;
          if (!v.wr && since == v.l) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = v.rd;
          end
        end
        if (cmd_ready) check("ready_while_busy", cmd_ready, 0);
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rsp_timeout: no response after %0d cycles, expected at %0d", k, exp_lat);
      void'(exp_q.pop_front());
      apply_reset();
    end
  endtask

  // ---------------- global watchdog ----------------
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main test ----------------
  vec_t vecs[8];
  logic rdy_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic rsp_pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic wr_pat[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    vec_t v;
    logic [DW-1:0] held;

    vecs[0] = '{wr:1'b1, addr:16'h0001, be:4'hF, wd:32'hDEADBEEF, w:0, l:0, rd:32'h0};
    vecs[1] = '{wr:1'b0, addr:16'h0002, be:4'hF, wd:32'h0,        w:4, l:2, rd:32'h12345678};
    vecs[2] = '{wr:1'b0, addr:16'h0003, be:4'hF, wd:32'h0,        w:0, l:0, rd:32'hA5A5_0F0F};
    vecs[3] = '{wr:1'b0, addr:16'hFFFF, be:4'h3, wd:32'h0,        w:2, l:0, rd:32'h0000_0001};
    vecs[4] = '{wr:1'b1, addr:16'h8000, be:4'h0, wd:32'h1122_3344, w:3, l:0, rd:32'h0};
    vecs[5] = '{wr:1'b0, addr:16'h0000, be:4'h0, wd:32'h0,        w:0, l:1, rd:32'hFFFF_FFFF};
    vecs[6] = '{wr:1'b1, addr:16'h1234, be:4'h5, wd:32'h0,        w:1, l:3, rd:32'h0};
    vecs[7] = '{wr:1'b0, addr:16'h4321, be:4'hA, wd:32'h0,        w:1, l:3, rd:32'h0BAD_F00D};

    // Reset values, sampled while reset is still asserted.
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_write", avm_write, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_write", rsp_write, 0);
    check("rst_avm_address", avm_address, 0);
    check("rst_avm_byteenable", avm_byteenable, 0);
    check("rst_avm_writedata", avm_writedata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Random transactions, with occasional stray readdatavalid while idle.
    for (int i = 0; i < 40; i++) begin
      v.wr   = 1'($urandom_range(0, 1));
      v.addr = AW'($urandom);
      v.be   = ($urandom_range(0, 3) == 0) ? '0 : (DW/8)'($urandom);
      v.wd   = $urandom;
      v.w    = $urandom_range(0, 4);
      v.l    = $urandom_range(0, 3);
      v.rd   = $urandom;
      run_txn(v);
      if ($urandom_range(0, 2) == 0) begin
        held              = rsp_rdata;
        avm_readdatavalid = 1'b1;
        avm_readdata      = $urandom;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        check("idle_stray_no_rsp", rsp_valid, 0);
        check("idle_stray_rdata", rsp_rdata, held);
      end
    end

    // cmd_valid held high across two writes: second accepted only after rsp.
    avm_waitrequest = 1'b0;
    issue(1'b1, 16'h00A0, 4'hF, 32'h0000_AAAA);
    for (int i = 0; i < 6; i++) begin
      check("b2b_ready", cmd_ready, rdy_pat[i]);
      check("b2b_rsp_valid", rsp_valid, rsp_pat[i]);
      check("b2b_avm_write", avm_write, wr_pat[i]);
      if (i == 1) begin
        check("b2b_addr_a", avm_address, 16'h00A0);
        issue(1'b1, 16'h00B0, 4'hF, 32'h0000_BBBB);
      end
      if (i == 4) begin
        check("b2b_addr_b", avm_address, 16'h00B0);
        check("b2b_wdata_b", avm_writedata, 32'h0000_BBBB);
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_idle_after", cmd_ready, 1);

    // Reset while avm_read is high.
    avm_waitrequest = 1'b1;
    issue(1'b0, 16'h0055, 4'hF, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_rst_read_before", avm_read, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_read_async", avm_read, 0);
    check("mid_rst_ready_async", cmd_ready, 1);
    check("mid_rst_addr_async", avm_address, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", rsp_valid, 0);
    end
    reset_n         = 1'b1;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_read", avm_read, 0);
    end

    // Waitrequest stuck high.
    avm_waitrequest = 1'b1;
    issue(1'b0, 16'h0077, 4'hF, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
`ifdef AV_MM_MASTER_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      check("to_read_held", avm_read, 1);
      check("to_no_rsp_yet", rsp_valid, 0);
      @(negedge clk);
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_read_dropped", avm_read, 0);
    @(negedge clk);
    check("to_ready_after", cmd_ready, 1);
    check("to_err_cleared", rsp_err, 0);
`else
    for (int k = 1; k <= 30; k++) begin
      check("stuck_read_held", avm_read, 1);
      check("stuck_no_rsp", rsp_valid, 0);
      check("stuck_no_err", rsp_err, 0);
      @(negedge clk);
    end
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'hCAFE_F00D;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    check("stuck_rsp_valid", rsp_valid, 1);
    check("stuck_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("stuck_rsp_err", rsp_err, 0);
    @(negedge clk);
    check("stuck_ready_after", cmd_ready, 1);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
